// File: rtl/lora_pkg.sv
// Shared definitions for the LoRa frame receiver: default frame bytes,
// parser / byte-receiver state encodings and baud-timing derivation.
package lora_pkg;

    localparam logic [7:0] HEAD_DEF    = 8'hA5;
    localparam logic [7:0] TYPE_ID_DEF = 8'h01;
    localparam logic [7:0] TAIL_DEF    = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TYPE = 3'd1,
        ST_DATA = 3'd2,
        ST_SUM  = 3'd3,
        ST_TAIL = 3'd4
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per UART bit (integer division).
    function automatic int bit_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Cycles from the start-bit falling edge to the start-bit centre.
    function automatic int half_div(input int clk_freq, input int baud);
        return bit_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_byte_rx
    import lora_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       byte_ferr
);

    localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD);
    localparam int HALF    = half_div(CLK_FREQ, BAUD);
    localparam int CW      = $clog2(BIT_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic [1:0]    sync_reg;
    logic          rx_prev;
    logic          rx_s;
    rx_state_t     rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    assign rx_s = sync_reg[1];

    // Bring the asynchronous line into clk and keep one past sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
            rx_prev  <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
            rx_prev  <= rx_s;
        end
    end

    // Bit timing and shifting; returns to idle right after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        // A high line at mid start bit means a glitch, not a byte.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        byte_data <= {rx_s, byte_data[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        rx_state  <= RX_IDLE;
                        byte_vld  <= rx_s;
                        byte_ferr <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lora_frame_rx.sv
// LoRa frame parser: HEAD TYPE DATA SUM TAIL, checksum = TYPE ^ DATA.
// Holds the last good payload, flags and counts discarded frames, and
// abandons a stalled frame after TIMEOUT_BYTES byte times of silence.
module lora_frame_rx
    import lora_pkg::*;
#(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         BAUD          = 9600,
    parameter logic [7:0] HEAD          = HEAD_DEF,
    parameter logic [7:0] TYPE_ID       = TYPE_ID_DEF,
    parameter logic [7:0] TAIL          = TAIL_DEF,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] data_tx,
    output logic       data_valid,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD);
    localparam int LIMIT   = TIMEOUT_BYTES * 10 * BIT_DIV;
    localparam int TW      = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LIMIT - 1);

    logic [7:0]   byte_data;
    logic         byte_vld;
    logic         byte_ferr;
    parse_state_t state;
    logic [7:0]   shadow;
    logic [TW-1:0] tmo;   // cycles since the last byte_vld; that cycle is 0
    logic         discard;
    logic         resync;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (uart_rxd),
        .byte_data (byte_data),
        .byte_vld  (byte_vld),
        .byte_ferr (byte_ferr)
    );

    // Decide whether the frame in progress must be dropped this cycle; a
    // received byte takes precedence over a coincident timeout.
    always_comb begin
        discard = 1'b0;
        resync  = 1'b0;
        if (state != ST_IDLE) begin
            if (byte_vld) begin
                case (state)
                    ST_TYPE: discard = (byte_data != TYPE_ID);
                    ST_SUM:  discard = (byte_data != (TYPE_ID ^ shadow));
                    ST_TAIL: begin
                        discard = (byte_data != TAIL);
                        resync  = (byte_data == HEAD);
                    end
                    default: discard = 1'b0;
                endcase
            end else if (byte_ferr) begin
                discard = 1'b1;
            end else if (tmo == TMO_LAST) begin
                discard = 1'b1;
            end
        end
    end

    // Parser FSM with timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            tmo        <= '0;
            data_tx    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (discard) begin
                frame_err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                // A HEAD arriving where TAIL was expected likely starts a new frame.
                state <= resync ? ST_TYPE : ST_IDLE;
                tmo   <= resync ? TW'(1) : '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tmo <= '0;
                        if (byte_vld && byte_data == HEAD) begin
                            state <= ST_TYPE;
                            tmo   <= TW'(1);
                        end
                    end
                    ST_TYPE: begin
                        tmo <= byte_vld ? TW'(1) : tmo + 1'b1;
                        if (byte_vld) state <= ST_DATA;
                    end
                    ST_DATA: begin
                        tmo <= byte_vld ? TW'(1) : tmo + 1'b1;
                        if (byte_vld) begin
                            shadow <= byte_data;
                            state  <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        tmo <= byte_vld ? TW'(1) : tmo + 1'b1;
                        if (byte_vld) state <= ST_TAIL;
                    end
                    ST_TAIL: begin
                        tmo <= byte_vld ? '0 : tmo + 1'b1;
                        if (byte_vld) begin
                            data_tx    <= shadow;
                            data_valid <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tmo   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lora_frame_rx.sv
// Directed bench for lora_frame_rx at a reduced bit rate (8 clocks per bit)
// so full frames, the timeout and error saturation fit in a short run.
module tb_lora_frame_rx;

    localparam int BIT_DIV = 8;
    localparam int HALF    = 4;
    localparam int TMO_LIM = 4 * 10 * BIT_DIV;
    // Line edge to stop-bit sample: 2 sync flops + 1 edge-detect edge,
    // HALF to the start-bit centre, 9 bit times to the stop-bit centre.
    localparam int STOP_SMP = 3 + HALF + 9 * BIT_DIV;
    // data_valid / discard strobe appears one commit edge after the sample.
    localparam int DV_LAT  = STOP_SMP + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] data_tx;
    logic       data_valid;
    logic       frame_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int last_dv_cyc = 0;
    int last_fe_cyc = 0;
    int last_start = 0;
    int fr_start[5];
    int fe_base;

    lora_frame_rx #(
        .CLK_FREQ      (80),
        .BAUD          (10),
        .HEAD          (8'hA5),
        .TYPE_ID       (8'h01),
        .TAIL          (8'h5A),
        .TIMEOUT_BYTES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .data_tx    (data_tx),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            last_dv_cyc = cyc;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            last_fe_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        uart_rxd = v;
        repeat (BIT_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        last_start = cyc;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) begin
            send_byte(f[39-8*i -: 8], 1'b1);
            fr_start[i] = last_start;
        end
        idle(2 * BIT_DIV);
        $display("frame %h: data_tx=%h err_cnt=%0d dv=%0d fe=%0d", f, data_tx, err_cnt, dv_cnt, fe_cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_data_tx", data_tx, 8'h00);
        check_eq("rst_data_valid", data_valid, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_err_cnt", err_cnt, 8'h00);
        rst_n = 1'b1;
        idle(2 * BIT_DIV);

        // Good frame
        send_frame(40'hA5_01_2A_2B_5A);
        check_eq("good_data", data_tx, 8'h2A);
        check_eq("good_dv_cnt", dv_cnt, 1);
        check_eq("good_latency", last_dv_cyc - fr_start[4], DV_LAT);
        check_eq("good_err_cnt", err_cnt, 8'd0);
        check_eq("good_fe_cnt", fe_cnt, 0);

        // Bad checksum: discarded at SUM, trailing 5A ignored in IDLE
        send_frame(40'hA5_01_2A_00_5A);
        check_eq("badsum_fe_cnt", fe_cnt, 1);
        check_eq("badsum_fe_cyc", last_fe_cyc - fr_start[3], DV_LAT);
        check_eq("badsum_err_cnt", err_cnt, 8'd1);
        check_eq("badsum_hold", data_tx, 8'h2A);
        check_eq("badsum_dv_cnt", dv_cnt, 1);

        // Framing error on the data byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2A, 1'b0);
        idle(3 * BIT_DIV);
        $display("ferr byte sent: err_cnt=%0d fe=%0d", err_cnt, fe_cnt);
        check_eq("ferr_fe_cnt", fe_cnt, 2);
        check_eq("ferr_err_cnt", err_cnt, 8'd2);
        send_frame(40'hA5_01_07_06_5A);
        check_eq("ferr_next_data", data_tx, 8'h07);
        check_eq("ferr_dv_cnt", dv_cnt, 2);

        // Timeout after TYPE
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        fe_base = last_start;
        idle(TMO_LIM + 40);
        $display("timeout wait done: err_cnt=%0d fe=%0d", err_cnt, fe_cnt);
        check_eq("tmo_fe_cnt", fe_cnt, 3);
        check_eq("tmo_fe_cyc", last_fe_cyc - fe_base, STOP_SMP + TMO_LIM);
        check_eq("tmo_err_cnt", err_cnt, 8'd3);
        send_frame(40'hA5_01_11_10_5A);
        check_eq("tmo_next_data", data_tx, 8'h11);

        // Garbage then back-to-back frame
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_frame(40'hA5_01_64_65_5A);
        check_eq("b2b_data", data_tx, 8'h64);
        check_eq("b2b_err_cnt", err_cnt, 8'd3);
        check_eq("b2b_dv_cnt", dv_cnt, 4);

        // HEAD in the TAIL slot: counted error, resync into a new frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2A, 1'b1);
        send_byte(8'h2B, 1'b1);
        send_frame(40'hA5_01_55_54_5A);
        check_eq("resync_err_cnt", err_cnt, 8'd4);
        check_eq("resync_data", data_tx, 8'h55);

        // Reset in the middle of the DATA byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        fork
            send_byte(8'h2A, 1'b1);
            begin
                repeat (3 * BIT_DIV + 4) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_eq("mrst_data_tx", data_tx, 8'h00);
                check_eq("mrst_err_cnt", err_cnt, 8'h00);
                check_eq("mrst_dv", data_valid, 1'b0);
                check_eq("mrst_fe", frame_err, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(12 * BIT_DIV);
        send_frame(40'hA5_01_FF_FE_5A);
        check_eq("mrst_next_data", data_tx, 8'hFF);
        check_eq("mrst_next_err", err_cnt, 8'd0);

        // Saturation: 256 bad-type frames
        fe_base = fe_cnt;
        for (int i = 0; i < 255; i++) begin
            send_byte(8'hA5, 1'b1);
            send_byte(8'h02, 1'b1);
        end
        idle(2 * BIT_DIV);
        $display("255 bad-type frames: err_cnt=%0d", err_cnt);
        check_eq("sat_255", err_cnt, 8'd255);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(2 * BIT_DIV);
        $display("256 bad-type frames: err_cnt=%0d", err_cnt);
        check_eq("sat_hold", err_cnt, 8'd255);
        check_eq("sat_fe_pulses", fe_cnt - fe_base, 256);
        check_eq("sat_data_hold", data_tx, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
